ahb_bus_arbiter: RTL and testbench

Round-robin AHB arbiter that shares the single AHB slave port of the AHB-to-APB bridge among `NUM_MASTERS` AHB masters. It drives one-hot `hgrant`, the address-phase and data-phase master indices that steer the master-side bus mux, and `hmastlock`. It sits between the masters and the bridge's `hwrite/htrans/haddr/hwdata` inputs, and observes the bridge's `hreadyout` as `hready`.

---
 rtl/ahb_pkg.sv | 21 ++
 rtl/ahb_bus_arbiter_rr_pick.sv | 36 +++
 rtl/ahb_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer-type encodings and the arbiter state
// encoding. Imported by the arbiter and by the bridge slave interface.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        PARK = 2'd0,  // no requests, grant parked on master 0
        OWN  = 2'd1,  // granted master active, unlocked
        LOCK = 2'd2   // granted master holds a locked sequence
    } arb_state_t;

    // A transfer that moves data (NONSEQ or SEQ) as opposed to IDLE/BUSY.
    function automatic logic is_beat(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage : ahb_pkg

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin select: the first set bit of req, searching
// upward from index start with wrap-around. Returns one-hot, index and a
// found flag. When nothing is requested all outputs are zero.
module rr_pick #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [MW-1:0] idx,
    output logic          found
);

    // Walk the request vector once from start; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int pos;
            pos = int'(start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                idx        = MW'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter in front of the AHB-to-APB bridge slave port.
// Produces a registered one-hot grant, the address-phase and data-phase
// owner indices for the master-side muxes, and hmastlock. Ownership is
// handed over only at arbitration points (hready high and either an IDLE
// transfer, a dropped request, or an exhausted hold budget while unlocked).
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS),
    parameter int MAX_HOLD    = 8
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_d,
    output logic                   hmastlock
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_t             state;
    logic [MW-1:0]          owner;      // index of the one-hot hgrant
    logic [HW-1:0]          hold_cnt;   // completed beats in this ownership

    logic [MW-1:0]          search_start;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [MW-1:0]          pick_idx;
    logic                   pick_found;

    logic                   others_req;
    logic                   trans_idle;
    logic                   hold_sat;
    logic                   arb_point;

    arb_state_t             next_state;
    logic [MW-1:0]          next_owner;
    logic [NUM_MASTERS-1:0] next_grant;
    logic                   owner_change;

    // Search begins one past the current owner so the owner is considered
    // last; if it is the only requester it keeps the bus.
    always_comb begin
        if (owner == MW'(NUM_MASTERS - 1)) begin
            search_start = '0;
        end else begin
            search_start = owner + 1'b1;
        end
    end

    rr_pick #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_rr_pick (
        .req   (hbusreq),
        .start (search_start),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign others_req = |(hbusreq & ~hgrant);
    assign trans_idle = (htrans == HTRANS_IDLE);
    assign hold_sat   = (hold_cnt >= HOLD_MAX);

    // Decide whether this cycle is an arbitration point (hready is applied
    // in the register block) and what the winner would be.
    always_comb begin
        arb_point  = 1'b0;
        next_state = state;
        next_owner = owner;
        next_grant = hgrant;

        unique case (state)
            PARK:    arb_point = |hbusreq;
            OWN:     arb_point = trans_idle || !hbusreq[owner] ||
                                 (hold_sat && others_req);
            LOCK:    arb_point = trans_idle &&
                                 (!hlock[owner] || !hbusreq[owner]);
            default: arb_point = 1'b1;
        endcase

        if (pick_found) begin
            next_owner = pick_idx;
            next_grant = pick_grant;
            next_state = hlock[pick_idx] ? LOCK : OWN;
        end else begin
            next_owner = '0;
            next_grant = NUM_MASTERS'(1);
            next_state = PARK;
        end

        // Hold budget restarts whenever ownership moves or the bus parks.
        owner_change = arb_point &&
                       ((next_owner != owner) || (next_state == PARK));
    end

    // Arbiter FSM with registered grant, owner indices, lock and hold count.
    always_ff @(posedge hclk or posedge hreset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // right-hand side sees the pre-edge value (hmaster_d takes the old
        // hmaster, not the one being written on this edge).
        if (hreset) begin
            state     <= PARK;
            owner     <= '0;
            hgrant    <= NUM_MASTERS'(1);
            hmaster   <= '0;
            hmaster_d <= '0;
            hmastlock <= 1'b0;
            hold_cnt  <= '0;
        end else if (hready) begin
            hmaster   <= owner;
            hmaster_d <= hmaster;
            hmastlock <= (state == LOCK) && hlock[owner];

            if (arb_point) begin
                state  <= next_state;
                owner  <= next_owner;
                hgrant <= next_grant;
            end

            if (owner_change) begin
                hold_cnt <= '0;
            end else if ((state == OWN) && is_beat(htrans) && !hold_sat) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule : ahb_bus_arbiter

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 masters, MAX_HOLD 8): reset/park,
// round-robin rotation, hold-limit handover, locked bursts, wait states and
// asynchronous reset.
module tb_ahb_bus_arbiter;

    localparam int N = 4;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic         hclk = 1'b0;
    logic         hreset;
    logic [N-1:0] hbusreq;
    logic [N-1:0] hlock;
    logic [1:0]   htrans;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic [1:0]   hmaster_d;
    logic         hmastlock;

    int total = 0;
    int bad   = 0;

    ahb_bus_arbiter #(
        .NUM_MASTERS (N),
        .MAX_HOLD    (8)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmaster_d (hmaster_d),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, 32'(hgrant), 32'b0001);
        check({tag, "_hmaster"}, 32'(hmaster), 0);
        check({tag, "_hmaster_d"}, 32'(hmaster_d), 0);
        check({tag, "_lock"}, 32'(hmastlock), 0);
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        rr_exp[0] = 4'b0100;
        rr_exp[1] = 4'b1000;
        rr_exp[2] = 4'b0001;
        rr_exp[3] = 4'b0010;

        hreset  = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        htrans  = T_IDLE;
        hready  = 1'b1;

        // Reset / park
        step();
        step();
        check_reset_vals("rst");
        hreset = 1'b0;
        step();
        check("park_idle", 32'(hgrant), 32'b0001);
        hbusreq = 4'b0100;
        step();
        check("park_grant", 32'(hgrant), 32'b0100);
        check("park_hm_old", 32'(hmaster), 0);
        step();
        check("park_hm_new", 32'(hmaster), 2);

        // Move ownership to master 1, then rotate with all requesting
        hbusreq = 4'b0010;
        step();
        check("rr_setup", 32'(hgrant), 32'b0010);
        hbusreq = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            htrans = T_NONSEQ;
            step();
            check($sformatf("rr_hold%0d", k), 32'(hgrant),
                  (k == 0) ? 32'b0010 : 32'(rr_exp[k-1]));
            htrans = T_IDLE;
            step();
            check($sformatf("rr_next%0d", k), 32'(hgrant), 32'(rr_exp[k]));
        end

        // Fairness: master 0 bursts, master 3 waits
        hbusreq = 4'b0001;
        step();
        check("fair_setup", 32'(hgrant), 32'b0001);
        hbusreq = 4'b1001;
        htrans  = T_NONSEQ;
        for (int k = 0; k < 8; k++) begin
            step();
            htrans = T_SEQ;
            check($sformatf("fair_beat%0d", k), 32'(hgrant), 32'b0001);
        end
        step();
        check("fair_handover", 32'(hgrant), 32'b1000);
        check("fair_hm_old", 32'(hmaster), 0);
        step();
        check("fair_hm_new", 32'(hmaster), 3);

        // Locked 20-beat burst by master 2 with everyone requesting
        hbusreq = 4'b0100;
        hlock   = 4'b0100;
        htrans  = T_IDLE;
        step();
        check("lock_grant", 32'(hgrant), 32'b0100);
        hbusreq = 4'b1111;
        htrans  = T_NONSEQ;
        for (int k = 0; k < 20; k++) begin
            step();
            htrans = T_SEQ;
            check($sformatf("lock_g%0d", k), 32'(hgrant), 32'b0100);
            check($sformatf("lock_ml%0d", k), 32'(hmastlock), 1);
        end
        check("lock_hm", 32'(hmaster), 2);
        hlock   = 4'b0000;
        hbusreq = 4'b1011;
        htrans  = T_IDLE;
        step();
        check("unlock_grant", 32'(hgrant), 32'b1000);
        check("unlock_ml", 32'(hmastlock), 0);
        check("unlock_hm", 32'(hmaster), 2);
        check("unlock_hmd", 32'(hmaster_d), 2);

        // Wait states with a handover pending
        hbusreq = 4'b0001;
        hready  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("ws_g%0d", k), 32'(hgrant), 32'b1000);
            check($sformatf("ws_hm%0d", k), 32'(hmaster), 2);
            check($sformatf("ws_hmd%0d", k), 32'(hmaster_d), 2);
        end
        hready = 1'b1;
        step();
        check("ws_rel_g", 32'(hgrant), 32'b0001);
        check("ws_rel_hm", 32'(hmaster), 3);
        check("ws_rel_hmd", 32'(hmaster_d), 2);
        step();
        check("ws_rel2_hm", 32'(hmaster), 0);
        check("ws_rel2_hmd", 32'(hmaster_d), 3);

        // Async reset while master 3 owns a locked transfer
        hbusreq = 4'b1000;
        hlock   = 4'b1000;
        step();
        check("ar_grant", 32'(hgrant), 32'b1000);
        htrans = T_NONSEQ;
        step();
        check("ar_hm", 32'(hmaster), 3);
        check("ar_ml", 32'(hmastlock), 1);
        #2;
        hreset = 1'b1;
        #1;
        check_reset_vals("ar");
        #1;
        hreset  = 1'b0;
        hbusreq = '0;
        hlock   = '0;
        htrans  = T_IDLE;
        step();
        check("ar_after", 32'(hgrant), 32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ahb_bus_arbiter
